// File: rtl/pio_snapshot_pkg.sv
// pio_snapshot_pkg: register offsets relative to NUM_CH, CTRL bit
// positions and the auto-timer state type, shared by the snapshot bank
// and its auto-period timer.
package pio_snapshot_pkg;

  localparam int OFS_CTRL    = 0;
  localparam int OFS_PERIOD  = 1;
  localparam int OFS_SEQ     = 2;
  localparam int OFS_TSTAMP  = 3;
  localparam int OFS_EDGE    = 4;
  localparam int OFS_IRQMASK = 5;

  localparam int CTRL_SNAP_REQ = 0;
  localparam int CTRL_AUTO_EN  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/pio_auto_timer.sv
// pio_auto_timer: auto-period snapshot timer. Down-counter loaded with
// PERIOD-1; expire_o is high for the single cycle in which the counter
// sits at zero while running.
//
//   state | meaning
//   IDLE  | auto snapshots off (AUTO_EN=0 or PERIOD=0), counter held at 0
//   RUN   | counting down; terminal count requests a snapshot and reloads
module pio_auto_timer
  import pio_snapshot_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              auto_en_i,
  input  logic [DATA_W-1:0] period_i,
  input  logic              reload_i,
  output logic              expire_o
);

  timer_state_e      state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              run_ok;

  assign run_ok = auto_en_i && (period_i != '0);

  // State and down-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter reload/decrement and the expiry strobe.
  // A PERIOD rewrite reloads even when the count is mid-way.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_ok) begin
          state_d = RUN;
          cnt_d   = period_i - DATA_W'(1);
        end
      end
      RUN: begin
        if (!run_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q == '0) expire_o = 1'b1;
          if (reload_i || (cnt_q == '0)) cnt_d = period_i - DATA_W'(1);
          else                           cnt_d = cnt_q - DATA_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pio_snapshot_bank.sv
// pio_snapshot_bank: NUM_CH input channels latched coherently into SNAP
// registers on a manual or auto-period request, with sequence number and
// cycle timestamp, read through an Avalon-MM slave (read latency 1).
// Build option PIO_EDGE_IRQ_EN adds sticky per-channel change flags
// (EDGE), an IRQMASK register and the irq output.
module pio_snapshot_bank
  import pio_snapshot_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
`ifdef PIO_EDGE_IRQ_EN
  parameter int ADDR_W = $clog2(NUM_CH + 6)
`else
  parameter int ADDR_W = $clog2(NUM_CH + 4)
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_in,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [DATA_W-1:0]        avs_writedata,
  output logic [DATA_W-1:0]        avs_readdata,
  output logic                     avs_readdatavalid,
  output logic                     snap_pulse
`ifdef PIO_EDGE_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(NUM_CH + OFS_CTRL);
  localparam logic [ADDR_W-1:0] A_PERIOD  = ADDR_W'(NUM_CH + OFS_PERIOD);
  localparam logic [ADDR_W-1:0] A_SEQ     = ADDR_W'(NUM_CH + OFS_SEQ);
  localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(NUM_CH + OFS_TSTAMP);
`ifdef PIO_EDGE_IRQ_EN
  localparam logic [ADDR_W-1:0] A_EDGE    = ADDR_W'(NUM_CH + OFS_EDGE);
  localparam logic [ADDR_W-1:0] A_IRQMASK = ADDR_W'(NUM_CH + OFS_IRQMASK);
`endif

  logic [DATA_W-1:0] snap_q [NUM_CH];
  logic [DATA_W-1:0] seq_q, seq_d;
  logic [DATA_W-1:0] tstamp_q;
  logic [DATA_W-1:0] cyc_q, cyc_d;
  logic [DATA_W-1:0] period_q;
  logic              auto_en_q;
  logic              reload_q;
  logic              pulse_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  logic wr_ctrl, wr_period, snap_manual, snap_auto, snap_take;

  assign wr_ctrl     = avs_write && (avs_address == A_CTRL);
  assign wr_period   = avs_write && (avs_address == A_PERIOD);
  assign snap_manual = wr_ctrl && avs_writedata[CTRL_SNAP_REQ];
  assign snap_take   = snap_manual || snap_auto;
  assign seq_d       = seq_q + DATA_W'(1);
  assign cyc_d       = cyc_q + DATA_W'(1);

  pio_auto_timer #(
    .DATA_W (DATA_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .auto_en_i (auto_en_q),
    .period_i  (period_q),
    .reload_i  (reload_q),
    .expire_o  (snap_auto)
  );

  // Free-running cycle counter used as the snapshot timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  // CTRL/PERIOD registers; a PERIOD write arms a timer reload next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_en_q <= 1'b0;
      period_q  <= '0;
      reload_q  <= 1'b0;
    end else begin
      reload_q <= wr_period;
      if (wr_ctrl)   auto_en_q <= avs_writedata[CTRL_AUTO_EN];
      if (wr_period) period_q  <= avs_writedata;
    end
  end

  // Coherent capture of all channels plus SEQ/TSTAMP; coincident manual
  // and auto requests merge into one snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
      seq_q    <= '0;
      tstamp_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= snap_take;
      if (snap_take) begin
        for (int i = 0; i < NUM_CH; i++) snap_q[i] <= ch_in[i*DATA_W +: DATA_W];
        seq_q    <= seq_d;
        tstamp_q <= cyc_q;
      end
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  logic [NUM_CH*DATA_W-1:0] ch_prev_q;
  logic [NUM_CH-1:0]        edge_q, edge_d, edge_set, edge_clr;
  logic [NUM_CH-1:0]        mask_q;
  logic                     irq_q;

  // Sticky change flags; a change in the same cycle as a clear wins.
  always_comb begin
    edge_set = '0;
    for (int i = 0; i < NUM_CH; i++)
      edge_set[i] = |(ch_in[i*DATA_W +: DATA_W] ^ ch_prev_q[i*DATA_W +: DATA_W]);
    edge_clr = (avs_write && (avs_address == A_EDGE)) ? avs_writedata[NUM_CH-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;
  end

  // Previous-input, EDGE, IRQMASK and registered irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_prev_q <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      ch_prev_q <= ch_in;
      edge_q    <= edge_d;
      irq_q     <= |(edge_q & mask_q);
      if (avs_write && (avs_address == A_IRQMASK)) mask_q <= avs_writedata[NUM_CH-1:0];
    end
  end

  assign irq = irq_q;
`endif

  // Read mux over pre-edge register contents; unmapped addresses read 0.
  always_comb begin
    rdata_d = '0;
    if (avs_address == A_CTRL)        rdata_d[CTRL_AUTO_EN] = auto_en_q;
    else if (avs_address == A_PERIOD) rdata_d = period_q;
    else if (avs_address == A_SEQ)    rdata_d = seq_q;
    else if (avs_address == A_TSTAMP) rdata_d = tstamp_q;
`ifdef PIO_EDGE_IRQ_EN
    else if (avs_address == A_EDGE)    rdata_d = DATA_W'(edge_q);
    else if (avs_address == A_IRQMASK) rdata_d = DATA_W'(mask_q);
`endif
    else begin
      for (int i = 0; i < NUM_CH; i++)
        if (avs_address == ADDR_W'(i)) rdata_d = snap_q[i];
    end
  end

  // Registered read return; readdata holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= avs_read;
      if (avs_read) rdata_q <= rdata_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign snap_pulse        = pulse_q;

endmodule

// File: tb/tb_pio_snapshot_bank.sv
// tb_pio_snapshot_bank: directed scenarios plus randomized bus traffic,
// checked every cycle against a behavioural model that tracks auto
// snapshots as absolute due-cycles rather than a counter.
module tb_pio_snapshot_bank;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
`ifdef PIO_EDGE_IRQ_EN
  localparam int AW             = $clog2(NUM_CH + 6);
  localparam int FIRST_UNMAPPED = NUM_CH + 6;
`else
  localparam int AW             = $clog2(NUM_CH + 4);
  localparam int FIRST_UNMAPPED = NUM_CH + 4;
`endif
  localparam int A_CTRL   = NUM_CH;
  localparam int A_PERIOD = NUM_CH + 1;
  localparam int A_SEQ    = NUM_CH + 2;
  localparam int A_TS     = NUM_CH + 3;
  localparam int A_EDGE   = NUM_CH + 4;
  localparam int A_MASK   = NUM_CH + 5;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic [NUM_CH*DATA_W-1:0] ch = '0;
  logic [AW-1:0]            addr = '0;
  logic                     rd = 1'b0;
  logic                     wr = 1'b0;
  logic [DATA_W-1:0]        wdata = '0;
  logic [DATA_W-1:0]        rdata;
  logic                     rvalid;
  logic                     pulse;
`ifdef PIO_EDGE_IRQ_EN
  logic                     irq;
`endif

  always #5 clk = ~clk;

  pio_snapshot_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ch_in             (ch),
    .avs_address       (addr),
    .avs_read          (rd),
    .avs_write         (wr),
    .avs_writedata     (wdata),
    .avs_readdata      (rdata),
    .avs_readdatavalid (rvalid),
    .snap_pulse        (pulse)
`ifdef PIO_EDGE_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_snap [NUM_CH];
  logic [31:0] m_seq, m_ts, m_period, m_rdata;
  logic        m_auto, m_rvalid, m_pulse, m_reload;
  bit          m_armed;
  longint      m_edges, m_fire_at;
`ifdef PIO_EDGE_IRQ_EN
  logic [NUM_CH*DATA_W-1:0] m_prev;
  logic [NUM_CH-1:0]        m_edge, m_mask;
  logic                     m_irq;
`endif

  int          last_k, cnt, r_a, r_c;
  logic [31:0] last_ts, seq_before, r_d;
  logic        r_r, r_w;
  bit          have_ts, grab, found;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_snap[i] = '0;
    m_seq = '0; m_ts = '0; m_period = '0; m_rdata = '0;
    m_auto = 0; m_rvalid = 0; m_pulse = 0; m_reload = 0;
    m_armed = 0; m_edges = 0; m_fire_at = 0;
`ifdef PIO_EDGE_IRQ_EN
    m_prev = '0; m_edge = '0; m_mask = '0; m_irq = 0;
`endif
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < NUM_CH)     return m_snap[a];
    if (a == A_CTRL)    return {30'b0, m_auto, 1'b0};
    if (a == A_PERIOD)  return m_period;
    if (a == A_SEQ)     return m_seq;
    if (a == A_TS)      return m_ts;
`ifdef PIO_EDGE_IRQ_EN
    if (a == A_EDGE)    return 32'(m_edge);
    if (a == A_MASK)    return 32'(m_mask);
`endif
    return '0;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    int          a;
    logic [31:0] rv;
    bit          run_ok, fire, manual, snap;
`ifdef PIO_EDGE_IRQ_EN
    logic [NUM_CH-1:0] set;
`endif
    a      = int'(addr);
    rv     = model_read(a);
    run_ok = m_auto && (m_period != 0);
    fire   = m_armed && run_ok && (m_fire_at == m_edges);
    manual = wr && (a == A_CTRL) && wdata[0];
    snap   = manual || fire;
    if (!run_ok) m_armed = 0;
    else if (!m_armed) begin
      m_armed   = 1;
      m_fire_at = m_edges + longint'(m_period);
    end else if (m_reload || fire) m_fire_at = m_edges + longint'(m_period);
    m_reload = wr && (a == A_PERIOD);
    if (snap) begin
      for (int i = 0; i < NUM_CH; i++) m_snap[i] = ch[i*DATA_W +: DATA_W];
      m_ts  = 32'(m_edges);
      m_seq = m_seq + 1;
    end
    m_pulse  = snap;
    m_rvalid = rd;
    if (rd) m_rdata = rv;
`ifdef PIO_EDGE_IRQ_EN
    m_irq = |(m_edge & m_mask);
    for (int i = 0; i < NUM_CH; i++) set[i] = (ch[i*DATA_W +: DATA_W] != m_prev[i*DATA_W +: DATA_W]);
    if (wr && (a == A_EDGE)) m_edge = m_edge & ~wdata[NUM_CH-1:0];
    m_edge = m_edge | set;
    m_prev = ch;
    if (wr && (a == A_MASK)) m_mask = wdata[NUM_CH-1:0];
`endif
    if (wr && (a == A_CTRL))   m_auto = wdata[1];
    if (wr && (a == A_PERIOD)) m_period = wdata;
    m_edges++;
  endtask

  // One bus cycle: drive at negedge, cross the posedge, check at next negedge.
  task automatic step(input logic r, input logic w, input int a, input logic [31:0] d);
    rd = r; wr = w; addr = AW'(a); wdata = d;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    rd = 0; wr = 0;
    chk("rvalid", rvalid, m_rvalid);
    chk("snap_pulse", pulse, m_pulse);
    chk("rdata", rdata, m_rdata);
`ifdef PIO_EDGE_IRQ_EN
    chk("irq", irq, m_irq);
`endif
  endtask

  task automatic do_reset();
    reset_n = 0;
    for (int k = 0; k < 3; k++) begin
      rd = 1; wr = 1; addr = AW'($urandom); wdata = $urandom;
      for (int i = 0; i < NUM_CH; i++) ch[i*DATA_W +: DATA_W] = $urandom;
      #1;
      chk("rst_rdata", rdata, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_pulse", pulse, 0);
`ifdef PIO_EDGE_IRQ_EN
      chk("rst_irq", irq, 0);
`endif
      @(negedge clk);
    end
    rd = 0; wr = 0;
    reset_n = 1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // SEQ after reset, latency 1
    step(1, 0, A_SEQ, 0);
    chk("seq_after_reset", rdata, 0);
    chk("rvalid_latency1", rvalid, 1);
    step(0, 0, 0, 0);
    chk("rvalid_drop", rvalid, 0);

    // manual snapshot
    ch[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
    step(0, 1, A_CTRL, 32'h1);
    chk("manual_pulse", pulse, 1);
    ch[3*DATA_W +: DATA_W] = 32'h1;
    step(1, 0, 3, 0);
    chk("manual_pulse_single", pulse, 0);
    chk("snap3_held", rdata, 32'hDEADBEEF);
    step(1, 0, A_SEQ, 0);
    chk("seq_one", rdata, 1);
    step(1, 0, A_CTRL, 0);
    chk("ctrl_reads0", rdata, 0);

    // auto snapshots every 4 cycles
    step(0, 1, A_PERIOD, 4);
    step(0, 1, A_CTRL, 2);
    last_k = -1; have_ts = 0; grab = 0;
    for (int k = 0; k < 30; k++) begin
      step(1, 0, A_TS, 0);
      if (grab) begin
        if (have_ts) chk("tstamp_gap", rdata - last_ts, 4);
        last_ts = rdata; have_ts = 1; grab = 0;
      end
      if (pulse) begin
        if (last_k >= 0) chk("pulse_gap", k - last_k, 4);
        last_k = k; grab = 1;
      end
    end
    chk("auto_pulses_seen", last_k >= 0, 1);
    step(0, 1, A_PERIOD, 0);
    step(0, 0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0);
      if (pulse) cnt++;
    end
    chk("no_pulse_period0", cnt, 0);

    // coincident manual + auto request
    step(0, 1, A_PERIOD, 3);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_armed && m_auto && (m_period != 0) && (m_fire_at == m_edges)) found = 1;
      else step(0, 0, 0, 0);
    end
    chk("coinc_found", found, 1);
    seq_before = m_seq;
    step(0, 1, A_CTRL, 3);
    step(1, 0, A_SEQ, 0);
    chk("coinc_seq", rdata, seq_before + 1);
    step(0, 1, A_CTRL, 0);

    // unmapped addresses
    for (int a = FIRST_UNMAPPED; a < (1 << AW); a++) begin
      step(1, 1, a, 32'hFFFFFFFF);
      chk("unmapped_rd", rdata, 0);
    end

    // simultaneous read and write of PERIOD
    step(1, 1, A_PERIOD, 7);
    chk("rw_same_old", rdata, 3);
    step(1, 0, A_PERIOD, 0);
    chk("rw_same_new", rdata, 7);

    // read at the same edge as a snapshot returns the old value
    step(0, 1, A_PERIOD, 1);
    step(0, 1, A_CTRL, 2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    ch[0 +: DATA_W] = 32'hA5A50001;
    step(0, 0, 0, 0);
    ch[0 +: DATA_W] = 32'h5A5A0002;
    step(1, 0, 0, 0);
    chk("rd_old_snap", rdata, 32'hA5A50001);
    step(1, 0, 0, 0);
    chk("rd_new_snap", rdata, 32'h5A5A0002);
    step(0, 1, A_CTRL, 0);
    step(0, 0, 0, 0);

    // SEQ wrap
    force dut.seq_q = 32'hFFFFFFFF;
    #1;
    release dut.seq_q;
    m_seq = 32'hFFFFFFFF;
    step(1, 0, A_SEQ, 0);
    chk("seq_forced", rdata, 32'hFFFFFFFF);
    step(0, 1, A_CTRL, 1);
    step(1, 0, A_SEQ, 0);
    chk("seq_wrap", rdata, 0);

`ifdef PIO_EDGE_IRQ_EN
    // change detect and interrupt
    step(0, 1, A_MASK, 4);
    step(0, 1, A_EDGE, 32'hFF);
    step(0, 0, 0, 0);
    ch[2*DATA_W] = ~ch[2*DATA_W];
    step(0, 0, 0, 0);
    step(1, 0, A_EDGE, 0);
    chk("edge_bit2", rdata, 4);
    chk("irq_set", irq, 1);
    step(0, 1, A_EDGE, 4);
    step(0, 0, 0, 0);
    chk("irq_cleared", irq, 0);
    ch[1*DATA_W + 5] = ~ch[1*DATA_W + 5];
    step(0, 0, 0, 0);
    step(1, 0, A_EDGE, 0);
    chk("edge_bit1", rdata, 2);
    step(0, 0, 0, 0);
    chk("irq_masked", irq, 0);
    ch[2*DATA_W] = ~ch[2*DATA_W];
    step(0, 1, A_EDGE, 4);
    step(1, 0, A_EDGE, 0);
    chk("edge_set_wins", rdata, 6);
`endif

    // reset in the middle of an auto count
    step(0, 1, A_PERIOD, 5);
    step(0, 1, A_CTRL, 2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 0);
      if (pulse) cnt++;
    end
    chk("no_pulse_after_reset", cnt, 0);
    step(1, 0, A_PERIOD, 0);
    chk("period_after_reset", rdata, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          r_c = $urandom_range(0, NUM_CH - 1);
          ch[r_c*DATA_W +: DATA_W] = $urandom;
        end
        r_r = 1'($urandom_range(0, 1));
        r_w = ($urandom_range(0, 3) == 0);
        r_a = $urandom_range(0, (1 << AW) - 1);
        r_d = $urandom;
        if (r_w && (r_a == A_PERIOD)) r_d = $urandom_range(0, 6);
        if (r_w && (r_a == A_CTRL))
          r_d = ($urandom_range(0, 4) == 0) ? 32'(1 | ($urandom_range(0, 1) << 1))
                                            : 32'($urandom_range(0, 1) << 1);
        step(r_r, r_w, r_a, r_d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
